// File: rtl/des3_pkg.sv
// rtl/des3_pkg.sv - DES permutation tables, S-boxes, key shift schedule and FSM encodings for des3_main.
package des3_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [2:0] {IDLE, FETCH, STAGE, WRITE, DONE} state_t;
  typedef enum logic [1:0] {STG_NONE, STG_1, STG_2, STG_3} stage_t;
  typedef enum logic {MODE_ENC, MODE_DEC} mode_t;

  // Table entries count bit 1 as the MSB of the source word.
  localparam int IP_T [0:63] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [0:63] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [0:47] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [0:31] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [0:55] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [0:47] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [1:0] SHIFT_T [1:16] = '{2'd1,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,
                                            2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1};

  localparam logic [3:0] SBOX [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  // Six-bit group: outer bits pick the row, inner four bits the column.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    for (int i = 0; i < 8; i++) begin
      six = x[47-6*i -: 6];
      y[31-4*i -: 4] = SBOX[i][{six[5], six[0], six[4:1]}];
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Decrypt walks the schedule backwards: round 1 uses the unrotated halves.
  function automatic logic [1:0] shift_amt(input logic [4:0] round, input mode_t mode);
    if (round < 5'd1 || round > 5'd16) return 2'd0;
    if (mode == MODE_ENC) return SHIFT_T[round];
    if (round == 5'd1) return 2'd0;
    return SHIFT_T[5'd18 - round];
  endfunction

endpackage

// File: rtl/des_round.sv
// rtl/des_round.sv - one combinational DES Feistel round.
module des_round
  import des3_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [47:0] mixed;
  logic [31:0] f_out;

  assign mixed  = e_expand(r) ^ subkey;
  assign f_out  = p_perm(sbox_sub(mixed));
  assign l_next = r;
  assign r_next = l ^ f_out;

endmodule

// File: rtl/des3_main.sv
// rtl/des3_main.sv - 3DES EDE controller with iterative one-round-per-clock DES core.
// Optional DES3_DECRYPT_EN adds a decrypt input selecting the D(K3) E(K2) D(K1) sequence.
module des3_main
  import des3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef DES3_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [2:0]  done,
  output logic [0:7]  key_addr,
  input  logic [63:0] key,
  output logic [0:7]  data_addr,
  input  logic [63:0] dataIn,
  output logic [63:0] dataOut,
  input  logic [7:0]  encryp_data_addr,
  output logic        we,
  output logic [1:0]  des_stage
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);
  localparam logic [4:0] FINAL_CYC  = 5'(ROUNDS + 1);

  state_t      state, state_nx;
  stage_t      stage, stage_nx;
  logic [4:0]  cnt, cnt_nx;

  logic [63:0] k1, k2, k3, blk, stage_key, fp_out;
  logic [31:0] l_reg, r_reg, l_nx, r_nx;
  logic [27:0] c_reg, d_reg, c_rot, d_rot;
  logic [47:0] subkey;
  logic [1:0]  rot_amt;
  logic        dec_mode;
  mode_t       stage_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      stage <= STG_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      stage <= stage_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nx = FETCH;
        cnt_nx   = '0;
      end
      FETCH: if (cnt == 5'd3) begin
        state_nx = STAGE;
        stage_nx = STG_1;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 5'd1;
      end
      STAGE: if (cnt == FINAL_CYC) begin
        cnt_nx = '0;
        case (stage)
          STG_1:   stage_nx = STG_2;
          STG_2:   stage_nx = STG_3;
          default: begin
            stage_nx = STG_NONE;
            state_nx = WRITE;
          end
        endcase
      end else begin
        cnt_nx = cnt + 5'd1;
      end
      WRITE:   state_nx = DONE;
      default: state_nx = DONE;
    endcase
  end

  always_comb begin
    key_addr  = '0;
    data_addr = '0;
    we        = 1'b0;
    des_stage = 2'd0;
    case (state)
      FETCH: if (cnt < 5'd3) key_addr = {3'b000, cnt};
      STAGE: des_stage = stage;
      WRITE: begin
        data_addr = encryp_data_addr;
        we        = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DES3_DECRYPT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       dec_mode <= 1'b0;
    else if (state == IDLE && start)  dec_mode <= decrypt;
  end
`else
  assign dec_mode = 1'b0;
`endif

  // Decrypt sequence swaps the outer keys; the middle stage always inverts the outer mode.
  always_comb begin
    case (stage)
      STG_1:   stage_key = dec_mode ? k3 : k1;
      STG_2:   stage_key = k2;
      default: stage_key = dec_mode ? k1 : k3;
    endcase
  end

  assign stage_mode = ((stage == STG_2) ^ dec_mode) ? MODE_DEC : MODE_ENC;
  assign rot_amt    = shift_amt(cnt, stage_mode);
  assign c_rot      = (stage_mode == MODE_DEC) ? rotr28(c_reg, rot_amt) : rotl28(c_reg, rot_amt);
  assign d_rot      = (stage_mode == MODE_DEC) ? rotr28(d_reg, rot_amt) : rotl28(d_reg, rot_amt);
  assign subkey     = pc2_perm({c_rot, d_rot});
  assign fp_out     = fp_perm({r_reg, l_reg});

  des_round u_round (
    .l      (l_reg),
    .r      (r_reg),
    .subkey (subkey),
    .l_next (l_nx),
    .r_next (r_nx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k1      <= '0;
      k2      <= '0;
      k3      <= '0;
      blk     <= '0;
      l_reg   <= '0;
      r_reg   <= '0;
      c_reg   <= '0;
      d_reg   <= '0;
      done    <= '0;
      dataOut <= '0;
    end else begin
      case (state)
        IDLE: if (start) done <= '0;
        FETCH: case (cnt)
          5'd1: begin
            k1  <= key;
            blk <= dataIn;
          end
          5'd2:    k2 <= key;
          5'd3:    k3 <= key;
          default: ;
        endcase
        STAGE: begin
          if (cnt == 5'd0) begin
            {l_reg, r_reg} <= ip_perm(blk);
            {c_reg, d_reg} <= pc1_perm(stage_key);
          end else if (cnt <= LAST_ROUND) begin
            l_reg <= l_nx;
            r_reg <= r_nx;
            c_reg <= c_rot;
            d_reg <= d_rot;
          end else begin
            blk <= fp_out;
            case (stage)
              STG_1:   done[0] <= 1'b1;
              STG_2:   done[1] <= 1'b1;
              default: begin
                done[2] <= 1'b1;
                dataOut <= fp_out;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des3_main.sv
// tb/tb_des3_main.sv - directed and randomized 3DES runs checked against a software DES model.
module tb_des3_main;
  import des3_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  done;
  logic [0:7]  key_addr, data_addr;
  logic [63:0] key, dataIn, dataOut;
  logic [7:0]  encryp_data_addr;
  logic        we;
  logic [1:0]  des_stage;
`ifdef DES3_DECRYPT_EN
  logic        decrypt;
`endif

  int checks = 0;
  int errors = 0;
  int we_total = 0;
  logic [63:0] kmem [0:255];
  logic [63:0] dmem [0:255];
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;

  des3_main dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef DES3_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .done(done), .key_addr(key_addr), .key(key), .data_addr(data_addr),
    .dataIn(dataIn), .dataOut(dataOut), .encryp_data_addr(encryp_data_addr),
    .we(we), .des_stage(des_stage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    key    <= kmem[key_addr];
    dataIn <= dmem[data_addr];
    if (we) begin
      wr_addr  <= data_addr;
      wr_data  <= dataOut;
      we_total <= we_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Software DES: full subkey list up front, decrypt just walks it in reverse.
  function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] x, input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [47:0] e;
    logic [63:0] y, z;
    logic [31:0] l, r, s, f, t;
    logic [5:0]  six;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      repeat ((i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[i][47-j] = cd[56-PC2_T[j]];
    end
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    l = y[63:32];
    r = y[31:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
      e = e ^ (dec ? sk[15-i] : sk[i]);
      for (int b = 0; b < 8; b++) begin
        six = e[47-6*b -: 6];
        s[31-4*b -: 4] = SBOX[b][{six[5], six[0], six[4:1]}];
      end
      for (int j = 0; j < 32; j++) f[31-j] = s[32-P_T[j]];
      t = l ^ f;
      l = r;
      r = t;
    end
    z = {r, l};
    for (int i = 0; i < 64; i++) y[63-i] = z[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] des3_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c, input logic [63:0] x, input bit dec);
    if (dec) return des_ref(a, des_ref(b, des_ref(c, x, 1'b1), 1'b0), 1'b1);
    return des_ref(c, des_ref(b, des_ref(a, x, 1'b0), 1'b1), 1'b0);
  endfunction

  // Edge n=1 samples start; FETCH spans n=1..4, stages 18 edges each from n=5, WRITE at n=59.
  function automatic int exp_stage(input int n);
    return (n >= 5 && n <= 58) ? (n - 5) / 18 + 1 : 0;
  endfunction

  function automatic int exp_done(input int n);
    int k;
    k = (n < 5) ? 0 : (n - 5) / 18;
    if (k > 3) k = 3;
    return (1 << k) - 1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_stage", 64'(des_stage), 64'd0);
    chk("rst_key_addr", 64'(key_addr), 64'd0);
    chk("rst_data_addr", 64'(data_addr), 64'd0);
    chk("rst_dataOut", dataOut, 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_block(input string tag, input logic [63:0] exp, input logic [7:0] waddr,
                           input int abort_at);
    int base;
    base = we_total;
    encryp_data_addr = waddr;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      if (n == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk({tag, "_abort_done"}, 64'(done), 64'd0);
        chk({tag, "_abort_stage"}, 64'(des_stage), 64'd0);
        chk({tag, "_abort_we"}, 64'(we), 64'd0);
        chk({tag, "_abort_dataOut"}, dataOut, 64'd0);
        chk({tag, "_abort_addr"}, 64'({key_addr, data_addr}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_abort_nowrite"}, 64'(we_total - base), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      #1;
      if (n == 8) start = 1'b0;
      chk({tag, "_stage"}, 64'(des_stage), 64'(exp_stage(n)));
      chk({tag, "_done"}, 64'(done), 64'(exp_done(n)));
      chk({tag, "_we"}, 64'(we), 64'(n == 59));
      chk({tag, "_key_addr"}, 64'(key_addr), 64'((n >= 1 && n <= 3) ? n - 1 : 0));
      if (n == 59) begin
        chk({tag, "_wr_addr"}, 64'(data_addr), 64'(waddr));
        chk({tag, "_wr_data"}, dataOut, exp);
      end
    end
    chk({tag, "_we_count"}, 64'(we_total - base), 64'd1);
    chk({tag, "_mem_addr"}, 64'(wr_addr), 64'(waddr));
    chk({tag, "_mem_data"}, wr_data, exp);
    chk({tag, "_hold"}, dataOut, exp);
  endtask

  task automatic hold_in_done(input logic [63:0] exp);
    int base;
    base = we_total;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = ~start;
      @(posedge clk);
      #1;
      chk("done_hold_we", 64'(we), 64'd0);
      chk("done_hold_key_addr", 64'(key_addr), 64'd0);
      chk("done_hold_stage", 64'(des_stage), 64'd0);
      chk("done_hold_done", 64'(done), 64'd7);
      chk("done_hold_dataOut", dataOut, exp);
    end
    chk("done_hold_no_write", 64'(we_total - base), 64'd0);
    start = 1'b0;
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [63:0] pt);
    kmem[0] = a;
    kmem[1] = b;
    kmem[2] = c;
    dmem[0] = pt;
  endtask

  initial begin
    logic [63:0] ka, kb, kc, pt, ct;
    reset = 1'b0;
    start = 1'b0;
    encryp_data_addr = 8'h00;
`ifdef DES3_DECRYPT_EN
    decrypt = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      kmem[i] = 64'd0;
      dmem[i] = 64'd0;
    end

    do_reset();
    load(64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'h123456ABCD132536);
    run_block("kat1", 64'hC0B7A8D05F3A829C, 8'h40, 0);
    hold_in_done(64'hC0B7A8D05F3A829C);

    do_reset();
    load(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    run_block("kat_single", 64'h85E813540F0AB405, 8'h41, 0);

    do_reset();
    load(64'h0133457799BBCDFF, 64'h0123456789ABCDEF, 64'h0133457799BBCDFF, 64'h0123456789ABCDEF);
    run_block("ede_mixed", des3_ref(kmem[0], kmem[1], kmem[2], dmem[0], 1'b0), 8'h42, 0);

    do_reset();
    load(64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'h123456ABCD132536);
    run_block("abort", 64'hC0B7A8D05F3A829C, 8'h40, 30);
    run_block("rerun", 64'hC0B7A8D05F3A829C, 8'h40, 0);

    for (int t = 0; t < 3; t++) begin
      do_reset();
      ka = {$urandom(), $urandom()};
      kb = {$urandom(), $urandom()};
      kc = {$urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      load(ka, kb, kc, pt);
      run_block("rand", des3_ref(ka, kb, kc, pt, 1'b0), 8'($urandom_range(1, 255)), 0);
    end

`ifdef DES3_DECRYPT_EN
    do_reset();
    decrypt = 1'b1;
    load(64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'hAABB09182736CCDD, 64'hC0B7A8D05F3A829C);
    run_block("dec_kat", 64'h123456ABCD132536, 8'h50, 0);

    do_reset();
    ka = {$urandom(), $urandom()};
    kb = {$urandom(), $urandom()};
    kc = {$urandom(), $urandom()};
    pt = {$urandom(), $urandom()};
    ct = des3_ref(ka, kb, kc, pt, 1'b0);
    load(ka, kb, kc, ct);
    run_block("dec_rand", pt, 8'h51, 0);
    decrypt = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des3_main.md
Name: des3_main

Overview:
- Triple-DES (EDE) controller plus iterative DES datapath.
- Fetches three 64-bit keys from key memory and one 64-bit plaintext block from data memory.
- Runs E(K1), D(K2), E(K3) at one round per clock, then writes the ciphertext back to data memory at a caller-supplied address.
- Sits between two synchronous single-port memories (key ROM, data RAM) and a host that drives start and reset.

Parameters:
- ROUNDS, 16, DES rounds per stage (fixed; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled only in IDLE
- done  out  3  done[i] set when stage i+1 completes; 3'b111 = block finished
- key_addr  out  8 ([0:7])  key memory address
- key  in  64  key memory read data; 1-cycle latency after key_addr
- data_addr  out  8 ([0:7])  data memory address
- dataIn  in  64  data memory read data; 1-cycle latency
- dataOut  out  64  ciphertext to data memory
- encryp_data_addr  in  8  write address for the ciphertext
- we  out  1  data memory write enable
- des_stage  out  2  0 = not running; 1/2/3 = DES stage in progress

Behaviour:
- Reset (reset=0, async): state IDLE; done=0, we=0, des_stage=0, key_addr=0, data_addr=0, dataOut=0; all key/data registers cleared.
- IDLE: when start=1, clear done and go to FETCH.
- FETCH (4 cycles):
  - Drive key_addr 0,1,2 on successive cycles; latch K1,K2,K3 one cycle after each address.
  - data_addr=0 on the first cycle; latch plaintext one cycle later.
- STAGE s (s=1..3), des_stage=s, 18 cycles:
  - Cycle 0: apply IP and PC-1 to the stage key.
  - Cycles 1-16: one Feistel round per cycle.
  - Cycle 17: swap L/R, apply FP; result feeds the next stage; set done[s-1].
- Stage modes: stage 1 encrypts with K1; stage 2 decrypts with K2; stage 3 encrypts with K3.
- Key schedule:
  - Encrypt, round r: rotate C/D left by SHIFT[r], where SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, round 1: PC-2 of unrotated C/D.
  - Decrypt, round r≥2: rotate C/D right by SHIFT[18-r] before PC-2.
- Round function: E expansion, XOR with subkey, S1..S8, P permutation; standard FIPS 46-3 tables.
  - Bit 1 = MSB (bit 63) of each word.
  - Key parity bits are ignored.
- WRITE (1 cycle): data_addr=encryp_data_addr, dataOut=ciphertext, we=1; des_stage=0.
- DONE:
  - we=0, done=3'b111, dataOut holds the ciphertext.
  - The block stays in DONE until reset; start is ignored there.
- Total latency: start sampled → we high = 1 + 4 + 54 = 59 cycles.
- start is ignored outside IDLE; a start deassert mid-operation has no effect.
- Reset mid-operation aborts immediately with no write.
- we is never asserted except in WRITE, and is exactly one cycle wide.
- done bits are sticky until reset or a new start from IDLE.
- Address/data widths are fixed; no wrap-around handling is needed.

Optional Feature:
- Macro DES3_DECRYPT_EN.
- Defined:
  - Adds input port decrypt (1 bit), sampled with start.
  - decrypt=1 runs D(K3), E(K2), D(K1): stage 1 uses K3 in decrypt mode, stage 2 K2 encrypt, stage 3 K1 decrypt.
  - decrypt=0 is identical to the undefined build.
- Undefined: no port; always EDE encrypt.

Decomposition:
- Package des3_pkg:
  - IP, FP, E, P, PC-1, PC-2 index tables and S-box constant arrays.
  - SHIFT schedule.
  - State enum: IDLE, FETCH, STAGE, WRITE, DONE.
  - Stage/mode encodings.
- Sub-module des_round: combinational round with inputs L, R, 48-bit subkey and outputs L', R'.
- Key rotation and PC-2 stay in des3_main.

Test Plan:
- K1=K2=K3=AABB09182736CCDD, plaintext 123456ABCD132536, encryp_data_addr=8'h40, start=1 → we pulses once, 59 cycles after start; data_addr=8'h40; dataOut=C0B7A8D05F3A829C; done=3'b111.
- Same run, monitor des_stage and done:
  - des_stage steps 0→1→2→3→0, 18 cycles per stage.
  - done bits set at the end of each stage, in order.
- Key memory returns 0133457799BBCDFF / 0123456789ABCDEF / 0133457799BBCDFF, plaintext 0123456789ABCDEF → dataOut equals a software 3DES-EDE reference model.
- Assert reset low during stage 2 → all outputs return to reset values at once; no we pulse; after release with start=1, the full 59-cycle run repeats with the correct result.
- After DONE, toggle start without reset → no further fetches, no we, outputs hold.
- DES3_DECRYPT_EN build: feed the ciphertext from the first scenario with decrypt=1 → dataOut=123456ABCD132536.
